// File: rtl/processor_debugger_hex_word_formatter.sv
// rtl/processor_debugger_hex_word_formatter.sv - 32-bit word to framed ASCII hex byte stream for the debug UART
module processor_debugger_hex_word_formatter #(
    parameter logic [7:0] P_START_CHAR = 8'h24,
    parameter logic [7:0] P_SPLIT_CHAR = 8'h2C,
    parameter logic [7:0] P_STOP_CHAR0 = 8'h0D,
    parameter logic [7:0] P_STOP_CHAR1 = 8'h0A,
    parameter bit         P_UPPERCASE  = 1'b1
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iTXD_REQ,
    output logic        oTXD_BUSY,
    input  logic        iTXD_START_EN,
    input  logic        iTXD_SPLIT_EN,
    input  logic        iTXD_STOP_EN,
    input  logic [31:0] iTXD_DATA,
    output logic        oUART_REQ,
    input  logic        iUART_BUSY,
    output logic [7:0]  oUART_DATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HEX,
        S_SPLIT,
        S_STOP0,
        S_STOP1
    } state_t;

    state_t      r_state;
    logic        r_gap;        // 0: SEND phase, 1: GAP phase of the current byte
    logic [2:0]  r_nib;        // hex digit index, 0 = most significant nibble
    logic [31:0] r_word;
    logic        r_split_en;
    logic        r_stop_en;
    logic [7:0]  r_data;       // last byte handed to the UART

    state_t      w_state_nxt;
    state_t      w_after_split;
    state_t      w_after_hex;
    logic        w_gap_nxt;
    logic [2:0]  w_nib_nxt;
    logic        w_accept;
    logic        w_fire;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hex_char;
    logic [7:0]  w_byte;

    assign w_accept      = (r_state == S_IDLE) && iTXD_REQ;
    assign w_fire        = (r_state != S_IDLE) && !r_gap && !iUART_BUSY;
    assign w_after_split = r_stop_en ? S_STOP0 : S_IDLE;
    assign w_after_hex   = r_split_en ? S_SPLIT : w_after_split;

    // Digit k lives at bits 31-4k..28-4k, i.e. its LSB sits at 4*(7-k) = {~k, 2'b00}.
    assign w_nibble = r_word[{~r_nib, 2'b00} +: 4];

    // ASCII digit: '0'+n below ten, otherwise ('A'-10)+n or ('a'-10)+n.
    always_comb begin
        w_hex_char = 8'h30 + {4'h0, w_nibble};
        if (w_nibble > 4'd9) begin
            w_hex_char = (P_UPPERCASE ? 8'h37 : 8'h57) + {4'h0, w_nibble};
        end
    end

    // Byte offered in the current state's SEND phase.
    always_comb begin
        w_byte = r_data;
        case (r_state)
            S_START: w_byte = P_START_CHAR;
            S_HEX:   w_byte = w_hex_char;
            S_SPLIT: w_byte = P_SPLIT_CHAR;
            S_STOP0: w_byte = P_STOP_CHAR0;
            S_STOP1: w_byte = P_STOP_CHAR1;
            default: w_byte = r_data;
        endcase
    end

    // Next-state: SEND waits for the UART, GAP always lasts one cycle then moves to the next byte.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_nib_nxt   = r_nib;
        if (r_state == S_IDLE) begin
            w_gap_nxt = 1'b0;
            w_nib_nxt = 3'd0;
            if (iTXD_REQ) begin
                w_state_nxt = iTXD_START_EN ? S_START : S_HEX;
            end
        end else if (!r_gap) begin
            if (!iUART_BUSY) begin
                w_gap_nxt = 1'b1;
            end
        end else begin
            w_gap_nxt = 1'b0;
            case (r_state)
                S_START: w_state_nxt = S_HEX;
                S_HEX: begin
                    w_nib_nxt = r_nib + 3'd1;
                    if (r_nib == 3'd7) begin
                        w_state_nxt = w_after_hex;
                    end
                end
                S_SPLIT: w_state_nxt = w_after_split;
                S_STOP0: w_state_nxt = S_STOP1;
                S_STOP1: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, word latch and last-byte register.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state    <= S_IDLE;
            r_gap      <= 1'b0;
            r_nib      <= 3'd0;
            r_word     <= 32'h0;
            r_split_en <= 1'b0;
            r_stop_en  <= 1'b0;
            r_data     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_nib   <= w_nib_nxt;
            if (w_accept) begin
                r_word     <= iTXD_DATA;
                r_split_en <= iTXD_SPLIT_EN;
                r_stop_en  <= iTXD_STOP_EN;
            end
            if (w_fire) begin
                r_data <= w_byte;
            end
        end
    end

    assign oTXD_BUSY  = (r_state != S_IDLE);
    assign oUART_REQ  = w_fire;
    assign oUART_DATA = w_fire ? w_byte : r_data;

endmodule

// File: tb/tb_processor_debugger_hex_word_formatter.sv
// tb/tb_processor_debugger_hex_word_formatter.sv - self-checking bench for the hex word formatter
module tb_processor_debugger_hex_word_formatter;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] word;
        bit          s_en;
        bit          sp_en;
        bit          st_en;
        int          n;
        logic [95:0] exp_u;
        logic [95:0] exp_l;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txd_req = 1'b0;
    logic        s_en = 1'b0;
    logic        sp_en = 1'b0;
    logic        st_en = 1'b0;
    logic [31:0] txd_data = 32'h0;
    logic        uart_busy = 1'b0;
    int          busy_mode = 0;

    logic        busy_u, req_u, busy_l, req_l;
    logic [7:0]  data_u, data_l;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mon_viol = 0;
    int acc_cyc = 0;
    int fall_cyc = 0;
    bit prev_u = 1'b0;
    bit prev_l = 1'b0;
    bq_t got_u, got_l;
    int  req_cyc[$];

    always #5 clk = ~clk;

    processor_debugger_hex_word_formatter #(.P_UPPERCASE(1'b1)) dut_u (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iTXD_REQ(txd_req), .oTXD_BUSY(busy_u),
        .iTXD_START_EN(s_en), .iTXD_SPLIT_EN(sp_en), .iTXD_STOP_EN(st_en),
        .iTXD_DATA(txd_data), .oUART_REQ(req_u), .iUART_BUSY(uart_busy), .oUART_DATA(data_u)
    );

    processor_debugger_hex_word_formatter #(.P_UPPERCASE(1'b0)) dut_l (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iTXD_REQ(txd_req), .oTXD_BUSY(busy_l),
        .iTXD_START_EN(s_en), .iTXD_SPLIT_EN(sp_en), .iTXD_STOP_EN(st_en),
        .iTXD_DATA(txd_data), .oUART_REQ(req_l), .iUART_BUSY(uart_busy), .oUART_DATA(data_l)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // UART busy source: 0 = idle, 1 = random stalls, 2 = held busy.
    always @(posedge clk) begin
        #1;
        uart_busy = (busy_mode == 2) || (busy_mode == 1 && $urandom_range(0, 3) == 0);
    end

    // Byte capture plus strobe protocol watch.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_u) begin
                got_u.push_back(data_u);
                req_cyc.push_back(cyc);
            end
            if (req_l) got_l.push_back(data_l);
            if ((req_u || req_l) && uart_busy) mon_viol++;
            if ((req_u && prev_u) || (req_l && prev_l)) mon_viol++;
        end
        prev_u = req_u;
        prev_l = req_l;
    end

    // Reference: the word printed as 8 hex characters with optional framing.
    function automatic bq_t model(input logic [31:0] w, input bit s, input bit sp, input bit st, input bit up);
        bq_t   q;
        string hx;
        byte   c;
        hx = $sformatf("%08h", w);
        if (s) q.push_back(8'h24);
        for (int i = 0; i < 8; i++) begin
            c = hx[i];
            if (up && c >= "a" && c <= "f") c = c - 8'd32;
            q.push_back(c);
        end
        if (sp) q.push_back(8'h2C);
        if (st) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    function automatic bq_t unpack(input logic [95:0] v, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[95-8*i -: 8]);
        return q;
    endfunction

    function automatic bq_t tail(input bq_t q, input int base);
        bq_t r;
        for (int i = base; i < q.size(); i++) r.push_back(q[i]);
        return r;
    endfunction

    function automatic string fmt(input bq_t q);
        string s;
        s = "";
        for (int i = 0; i < q.size() && i < 16; i++) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cmp_q(input string name, input bq_t exp, input bq_t got);
        bit ok;
        checks++;
        ok = (exp.size() == got.size());
        for (int i = 0; ok && i < exp.size(); i++) if (exp[i] !== got[i]) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=[%s] expected=[%s]", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic cmp_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] w, input bit s, input bit sp, input bit st);
        int n;
        n = 0;
        while (busy_u && n < 2000) begin
            tick();
            n++;
        end
        if (busy_u) begin
            errors++;
            checks++;
            $display("FAIL issue_timeout busy=%0d expected=0", busy_u);
        end
        txd_data = w;
        s_en = s;
        sp_en = sp;
        st_en = st;
        txd_req = 1'b1;
        acc_cyc = cyc;
        tick();
        txd_req = 1'b0;
        txd_data = $urandom;
        s_en = $urandom_range(0, 1);
        sp_en = $urandom_range(0, 1);
        st_en = $urandom_range(0, 1);
    endtask

    task automatic finish_word(input string name);
        int n;
        n = 0;
        while (busy_u && n < 2000) begin
            tick();
            n++;
        end
        fall_cyc = cyc;
        if (busy_u) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout busy=%0d expected=0", name, busy_u);
        end
    endtask

    vec_t vecs[5];
    int   base, cbase, vio0, n;
    bit   r_s, r_sp, r_st;
    logic [31:0] r_w;

    initial begin
        vecs[0] = '{32'h1234ABCD, 1, 1, 0, 10, 96'h24_31_32_33_34_41_42_43_44_2C_00_00, 96'h24_31_32_33_34_61_62_63_64_2C_00_00};
        vecs[1] = '{32'h00000000, 0, 0, 1, 10, 96'h30_30_30_30_30_30_30_30_0D_0A_00_00, 96'h30_30_30_30_30_30_30_30_0D_0A_00_00};
        vecs[2] = '{32'h0000FACE, 0, 0, 0, 8,  96'h30_30_30_30_46_41_43_45_00_00_00_00, 96'h30_30_30_30_66_61_63_65_00_00_00_00};
        vecs[3] = '{32'hFFFFFFFF, 0, 0, 0, 8,  96'h46_46_46_46_46_46_46_46_00_00_00_00, 96'h66_66_66_66_66_66_66_66_00_00_00_00};
        vecs[4] = '{32'h9876543E, 1, 1, 1, 12, 96'h24_39_38_37_36_35_34_33_45_2C_0D_0A, 96'h24_39_38_37_36_35_34_33_65_2C_0D_0A};

        repeat (3) tick();
        cmp_i("reset_busy_u", busy_u, 0);
        cmp_i("reset_req_u", req_u, 0);
        cmp_i("reset_data_u", data_u, 0);
        cmp_i("reset_busy_l", busy_l, 0);
        cmp_i("reset_data_l", data_l, 0);
        rst = 1'b0;
        tick();

        // Vector table, UART always ready: exact bytes plus strobe timing.
        foreach (vecs[i]) begin
            base = got_u.size();
            cbase = req_cyc.size();
            vio0 = mon_viol;
            issue(vecs[i].word, vecs[i].s_en, vecs[i].sp_en, vecs[i].st_en);
            finish_word($sformatf("vec%0d", i));
            cmp_q($sformatf("vec%0d_upper", i), unpack(vecs[i].exp_u, vecs[i].n), tail(got_u, base));
            cmp_q($sformatf("vec%0d_lower", i), unpack(vecs[i].exp_l, vecs[i].n), tail(got_l, base));
            n = req_cyc.size();
            if (n > cbase) begin
                cmp_i($sformatf("vec%0d_first_req_cycle", i), req_cyc[cbase], acc_cyc + 1);
                for (int k = cbase + 1; k < n; k++)
                    cmp_i($sformatf("vec%0d_req_spacing", i), req_cyc[k] - req_cyc[k-1], 2);
                cmp_i($sformatf("vec%0d_busy_fall_cycle", i), fall_cyc, req_cyc[n-1] + 2);
            end
            cmp_i($sformatf("vec%0d_protocol", i), mon_viol, vio0);
        end

        // UART stall after the second byte.
        base = got_u.size();
        vio0 = mon_viol;
        issue(32'hDEADBEEF, 0, 0, 0);
        n = 0;
        while (got_u.size() < base + 2 && n < 200) begin
            tick();
            n++;
        end
        busy_mode = 2;
        repeat (20) tick();
        cmp_i("stall_no_bytes", got_u.size() - base, 2);
        busy_mode = 0;
        finish_word("stall");
        cmp_q("stall_seq", unpack(96'h44_45_41_44_42_45_45_46_00_00_00_00, 8), tail(got_u, base));
        cmp_i("stall_protocol", mon_viol, vio0);

        // Request while busy is dropped; a request in the first idle cycle is taken.
        base = got_u.size();
        issue(32'h12345678, 1, 0, 0);
        repeat (3) tick();
        txd_data = 32'hFFFFFFFF;
        s_en = 1'b1;
        sp_en = 1'b1;
        st_en = 1'b1;
        txd_req = 1'b1;
        tick();
        txd_req = 1'b0;
        finish_word("ignore");
        cmp_q("ignore_first_only", model(32'h12345678, 1, 0, 0, 1), tail(got_u, base));
        base = got_u.size();
        cbase = req_cyc.size();
        issue(32'hFFFFFFFF, 0, 0, 0);
        finish_word("back2back");
        cmp_q("back2back_seq", unpack(96'h46_46_46_46_46_46_46_46_00_00_00_00, 8), tail(got_u, base));
        if (req_cyc.size() > cbase) cmp_i("back2back_latency", req_cyc[cbase], acc_cyc + 1);

        // Reset in the middle of a word.
        base = got_u.size();
        issue(32'h89ABCDEF, 0, 0, 0);
        n = 0;
        while (got_u.size() < base + 4 && n < 200) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        cmp_i("midreset_busy", busy_u, 0);
        cmp_i("midreset_req", req_u, 0);
        rst = 1'b0;
        repeat (10) tick();
        cmp_q("midreset_partial", unpack(96'h38_39_41_42_00_00_00_00_00_00_00_00, 4), tail(got_u, base));
        base = got_u.size();
        issue(32'h89ABCDEF, 0, 0, 0);
        finish_word("postreset");
        cmp_q("postreset_word", model(32'h89ABCDEF, 0, 0, 0, 1), tail(got_u, base));

        // Random words and flags against the reference, UART stalling at random.
        busy_mode = 1;
        for (int t = 0; t < 25; t++) begin
            r_w = $urandom;
            r_s = $urandom_range(0, 1);
            r_sp = $urandom_range(0, 1);
            r_st = $urandom_range(0, 1);
            base = got_u.size();
            vio0 = mon_viol;
            issue(r_w, r_s, r_sp, r_st);
            finish_word("rand");
            cmp_q($sformatf("rand%0d_upper_%08h", t, r_w), model(r_w, r_s, r_sp, r_st, 1), tail(got_u, base));
            cmp_q($sformatf("rand%0d_lower_%08h", t, r_w), model(r_w, r_s, r_sp, r_st, 0), tail(got_l, base));
            cmp_i($sformatf("rand%0d_protocol", t), mon_viol, vio0);
        end
        busy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
